// File: rtl/weighted_burst_arbiter.sv
// Per-slave burst arbiter for the crossbar forward path: weighted round-robin or fixed priority.
// The grant is registered and held for a whole burst; beat_accept strobes each transferred beat.
module weighted_burst_arbiter #(
    parameter int unsigned masters           = 4,
    parameter int unsigned slaves            = 4,
    parameter int unsigned i_am_slave_number = 0,
    parameter int unsigned weight_w          = 4,
    parameter bit          rr_mode           = 1'b1
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [masters-1:0]                master_fifo_empty,
    input  logic [masters*$clog2(slaves)-1:0] master_slave_dest,
    input  logic [masters-1:0]                master_last,
    input  logic [masters*weight_w-1:0]       master_weight,
    input  logic                              slave_fifo_full,
    output logic                              grant_valid,
    output logic [$clog2(masters)-1:0]        grant_master_number,
    output logic [masters-1:0]                grant_onehot,
    output logic                              beat_accept
);

    localparam int unsigned DW = $clog2(slaves);
    localparam int unsigned MW = $clog2(masters);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e              r_state;
    logic [MW-1:0]       r_holder;
    logic [MW-1:0]       r_ptr;
    logic [weight_w-1:0] r_credit;
    logic [masters-1:0]  r_onehot;

    logic [masters-1:0]  w_req;
    logic                w_keep;
    logic                w_forfeit;
    logic [MW-1:0]       w_start;
    logic                w_found;
    logic [MW-1:0]       w_pick;
    logic [weight_w-1:0] w_pick_weight;
    logic [weight_w-1:0] w_new_credit;
    logic [weight_w-1:0] w_credit_dec;
    logic [masters-1:0]  w_pick_oh;
    logic [masters-1:0]  w_holder_oh;

    function automatic logic [MW-1:0] wrap_inc(input logic [MW-1:0] x);
        return (x == MW'(masters - 1)) ? '0 : x + 1'b1;
    endfunction

    always_comb begin
        w_req = '0;
        for (int unsigned i = 0; i < masters; i++) begin
            w_req[i] = ~master_fifo_empty[i]
                     & (master_slave_dest[i*DW +: DW] == DW'(i_am_slave_number));
        end
    end

    assign w_keep    = (r_credit != '0) & w_req[r_holder];
    // A holder with credit left but nothing queued gives up its turn to the next index.
    assign w_forfeit = (r_credit != '0) & ~w_req[r_holder] & (|w_req);
    assign w_start   = w_forfeit ? wrap_inc(r_holder) : r_ptr;

    always_comb begin
        int unsigned idx;
        idx           = 0;
        w_found       = 1'b0;
        w_pick        = '0;
        w_pick_weight = '0;
        w_pick_oh     = '0;
        w_holder_oh   = '0;
        for (int unsigned k = 0; k < masters; k++) begin
            idx = 32'(w_start) + k;
            if (idx >= masters) idx = idx - masters;
            if (!w_found && w_req[MW'(idx)]) begin
                w_found = 1'b1;
                w_pick  = MW'(idx);
            end
        end
        for (int unsigned i = 0; i < masters; i++) begin
            if (MW'(i) == w_pick) begin
                w_pick_weight = master_weight[i*weight_w +: weight_w];
                w_pick_oh[i]  = 1'b1;
            end
            if (MW'(i) == r_holder) w_holder_oh[i] = 1'b1;
        end
    end

    assign w_new_credit = (!rr_mode || w_pick_weight == '0) ? weight_w'(1) : w_pick_weight;
    assign w_credit_dec = r_credit - 1'b1;

    assign beat_accept = (r_state == StLocked) & ~slave_fifo_full & ~master_fifo_empty[r_holder];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state  <= StIdle;
            r_holder <= '0;
            r_ptr    <= '0;
            r_credit <= '0;
            r_onehot <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_keep) begin
                        r_state  <= StLocked;
                        r_onehot <= w_holder_oh;
                    end else if (w_found) begin
                        r_state  <= StLocked;
                        r_holder <= w_pick;
                        r_credit <= w_new_credit;
                        r_onehot <= w_pick_oh;
                        if (w_forfeit && rr_mode) r_ptr <= w_start;
                    end
                end
                StLocked: begin
                    if (beat_accept && master_last[r_holder]) begin
                        r_state  <= StIdle;
                        r_onehot <= '0;
                        r_credit <= w_credit_dec;
                        if (w_credit_dec == '0) r_ptr <= rr_mode ? wrap_inc(r_holder) : '0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign grant_valid         = (r_state == StLocked);
    assign grant_master_number = r_holder;
    assign grant_onehot        = r_onehot;

endmodule

// File: tb/tb_weighted_burst_arbiter.sv
// Bench for weighted_burst_arbiter: directed scenarios plus random traffic, checked every cycle
// against a turn/credit reference model for a round-robin and a fixed-priority instance.
module tb_weighted_burst_arbiter;

    localparam int M = 4;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [3:0]  empty = 4'hF;
    logic [7:0]  dest = 8'h00;
    logic [3:0]  last = 4'h0;
    logic [15:0] weight = 16'h1111;
    logic        full = 1'b0;

    logic        gv0, gv1, ba0, ba1;
    logic [1:0]  gmn0, gmn1;
    logic [3:0]  oh0, oh1;

    weighted_burst_arbiter #(
        .masters(4), .slaves(4), .i_am_slave_number(0), .weight_w(4), .rr_mode(1'b1)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .master_fifo_empty(empty), .master_slave_dest(dest),
        .master_last(last), .master_weight(weight), .slave_fifo_full(full),
        .grant_valid(gv0), .grant_master_number(gmn0), .grant_onehot(oh0), .beat_accept(ba0)
    );

    weighted_burst_arbiter #(
        .masters(4), .slaves(4), .i_am_slave_number(0), .weight_w(4), .rr_mode(1'b0)
    ) dut_fp (
        .ACLK(ACLK), .ARESET(ARESET), .master_fifo_empty(empty), .master_slave_dest(dest),
        .master_last(last), .master_weight(weight), .slave_fifo_full(full),
        .grant_valid(gv1), .grant_master_number(gmn1), .grant_onehot(oh1), .beat_accept(ba1)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;
    // Model: is a burst in progress, who owns the turn, where the next search starts,
    // and how many bursts remain in the owner's turn.
    int m_busy[2], m_owner[2], m_start[2], m_left[2];
    int beat_cnt[4], burst_len[4];
    bit auto_last = 1'b0;
    bit prev_gv[2];
    int ord0[$], ord1[$];
    int acc2 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit req(input int i);
        return !empty[i] && (dest[i*2 +: 2] == 2'd0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_owner[k] = 0; m_start[k] = 0; m_left[k] = 0; prev_gv[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        int s, found, any_req;
        logic [3:0] wt;
        bit rr;
        rr = (k == 0);
        any_req = 0;
        for (int i = 0; i < M; i++) if (req(i)) any_req = 1;
        if (m_busy[k] == 0) begin
            if (m_left[k] > 0 && req(m_owner[k])) begin
                m_busy[k] = 1;
            end else if (any_req != 0) begin
                s = m_start[k];
                if (m_left[k] > 0) begin
                    s = (m_owner[k] + 1) % M;
                    if (rr) m_start[k] = s;
                end
                found = 0;
                for (int j = 0; j < M; j++) begin
                    if (found == 0 && req((s + j) % M)) begin
                        found = 1;
                        m_owner[k] = (s + j) % M;
                    end
                end
                wt = weight[m_owner[k]*4 +: 4];
                m_left[k] = (!rr || wt == 4'd0) ? 1 : int'(wt);
                m_busy[k] = 1;
            end
        end else if (!full && !empty[m_owner[k]] && last[m_owner[k]]) begin
            m_left[k] = m_left[k] - 1;
            m_busy[k] = 0;
            if (m_left[k] == 0) m_start[k] = rr ? (m_owner[k] + 1) % M : 0;
        end
    endtask

    task automatic check_inst(input int k, input logic gv, input logic [1:0] gmn,
                              input logic [3:0] oh, input logic ba);
        logic [3:0] e_oh;
        logic e_ba;
        e_oh = (m_busy[k] != 0) ? 4'(1 << m_owner[k]) : 4'b0;
        e_ba = (m_busy[k] != 0) && !full && !empty[m_owner[k]];
        check($sformatf("grant_valid[%0d]", k), {31'b0, gv}, 32'(m_busy[k]));
        check($sformatf("grant_master_number[%0d]", k), {30'b0, gmn}, 32'(m_owner[k]));
        check($sformatf("grant_onehot[%0d]", k), {28'b0, oh}, {28'b0, e_oh});
        check($sformatf("beat_accept[%0d]", k), {31'b0, ba}, {31'b0, e_ba});
        if (gv && !prev_gv[k]) begin
            if (k == 0) ord0.push_back(int'(gmn));
            else ord1.push_back(int'(gmn));
        end
        prev_gv[k] = gv;
    endtask

    task automatic set_last();
        if (auto_last)
            for (int i = 0; i < M; i++) last[i] = (beat_cnt[i] == burst_len[i] - 1);
    endtask

    task automatic step();
        @(negedge ACLK);
        check_inst(0, gv0, gmn0, oh0, ba0);
        check_inst(1, gv1, gmn1, oh1, ba1);
        if (gv0 && ba0 && gmn0 == 2'd2) acc2++;
        if (ARESET) begin
            model_reset();
        end else begin
            if (m_busy[0] != 0 && !full && !empty[m_owner[0]])
                beat_cnt[m_owner[0]] = (beat_cnt[m_owner[0]] + 1) % burst_len[m_owner[0]];
            model_step(0);
            model_step(1);
        end
        @(posedge ACLK);
        #1;
        set_last();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic check_order(input int k, input string tag, input string seq);
        int obs, sz;
        sz = (k == 0) ? ord0.size() : ord1.size();
        for (int i = 0; i < seq.len(); i++) begin
            obs = (i < sz) ? ((k == 0) ? ord0[i] : ord1[i]) : -1;
            check($sformatf("%s[%0d]", tag, i), obs, int'(seq[i]) - 48);
        end
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        model_reset();
        run(2);
        ARESET = 1'b0;
        for (int i = 0; i < M; i++) beat_cnt[i] = 0;
        ord0.delete();
        ord1.delete();
        acc2 = 0;
        set_last();
    endtask

    initial begin
        for (int i = 0; i < M; i++) begin
            beat_cnt[i] = 0;
            burst_len[i] = 1;
        end
        model_reset();
        #1;
        do_reset();

        // Idle: no requests for 10 cycles
        empty = 4'hF;
        run(10);
        check("idle_grants", ord0.size() + ord1.size(), 0);

        // Round-robin fairness, 2-beat bursts, unit weights
        dest = 8'h00; weight = 16'h1111; auto_last = 1'b1;
        for (int i = 0; i < M; i++) burst_len[i] = 2;
        set_last();
        empty = 4'h0;
        run(15);
        check_order(0, "rr_order", "01230");

        // Weighted: master 1 gets three 1-beat bursts per turn
        do_reset();
        weight = 16'h1131;
        for (int i = 0; i < M; i++) burst_len[i] = 1;
        set_last();
        empty = 4'h0;
        run(15);
        check_order(0, "wrr_order", "0111230");

        // Burst lock under backpressure and mid-burst empty head
        do_reset();
        weight = 16'h1111;
        burst_len[2] = 4;
        set_last();
        empty = 4'b1011;
        run(1);
        empty[0] = 1'b0; full = 1'b1;
        run(3);
        full = 1'b0; empty[2] = 1'b1;
        run(2);
        empty[2] = 1'b0;
        run(5);
        check("lock_beats", acc2, 4);
        run(2);
        check_order(0, "lock_order", "20");

        // Forfeit: master 1 has credit left but runs dry while 0 and 3 request
        do_reset();
        weight = 16'h1141;
        for (int i = 0; i < M; i++) burst_len[i] = 1;
        set_last();
        empty = 4'b1101;
        run(2);
        empty = 4'b0110;
        run(4);
        check_order(0, "forfeit_order", "130");

        // Fixed priority and destination filtering: master 1 targets slave 1
        do_reset();
        weight = 16'h1111;
        dest = 8'b00_00_01_00;
        empty = 4'b1000;
        run(11);
        check_order(1, "fp_order", "00000");
        check_order(0, "rr_filter_order", "02020");

        // Asynchronous reset in the middle of a 4-beat burst
        do_reset();
        dest = 8'h00;
        burst_len[0] = 4;
        set_last();
        empty = 4'b1110;
        run(2);
        ARESET = 1'b1;
        #1;
        check("async_gv0", {31'b0, gv0}, 0);
        check("async_ba0", {31'b0, ba0}, 0);
        check("async_oh0", {28'b0, oh0}, 0);
        check("async_gmn0", {30'b0, gmn0}, 0);
        check("async_gv1", {31'b0, gv1}, 0);
        check("async_ba1", {31'b0, ba1}, 0);
        model_reset();
        step();
        do_reset();

        // Random traffic against the model
        auto_last = 1'b0;
        repeat (400) begin
            for (int i = 0; i < M; i++) begin
                empty[i] = ($urandom_range(0, 9) < 3);
                dest[i*2 +: 2] = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(0, 3));
                last[i] = 1'($urandom_range(0, 1));
                weight[i*4 +: 4] = 4'($urandom_range(0, 5));
            end
            full = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
